// File: rtl/tail_light_decoder_if.sv
// Tail-light monitor bus: the observed 6-bit light pattern and error clear
// going into the decoder, and the direction/status flags coming back out.
interface tail_light_decoder_if #(
  parameter int CNT_W = 8
);
  logic [5:0]       light;
  logic             err_clr;
  logic             dir_left;
  logic             dir_right;
  logic             seq_done;
  logic             seq_dir;
  logic             err_pulse;
  logic             err_sticky;
  logic [CNT_W-1:0] done_count;

  modport master (
    output light, err_clr,
    input  dir_left, dir_right, seq_done, seq_dir, err_pulse, err_sticky, done_count
  );

  modport slave (
    input  light, err_clr,
    output dir_left, dir_right, seq_done, seq_dir, err_pulse, err_sticky, done_count
  );
endinterface

// File: rtl/tail_light_decoder.sv
// Receive-side checker for the tail-light sequencer bus. Tracks the legal
// 001 -> 011 -> 111 -> 000 sweep on either the left (light[5:3]) or right
// (light[2:0]) group, reports direction, completed sweeps and illegal
// patterns. Every output is registered: the pattern sampled on one edge is
// reflected on the outputs right after that edge.
// Optional: define TAIL_DECODER_HOLD_EN to let each sweep step repeat for up
// to HOLD_MAX extra cycles (sequencers running off a slow enable).
module tail_light_decoder #(
  parameter int CNT_W    = 8,
  parameter int HOLD_MAX = 3
) (
  input logic                 clk,
  input logic                 reset,
  tail_light_decoder_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    L1   = 3'd1,
    L2   = 3'd2,
    L3   = 3'd3,
    R1   = 3'd4,
    R2   = 3'd5,
    R3   = 3'd6,
    ERR  = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  if (HOLD_MAX < 0) begin : g_hold_range
    $error("HOLD_MAX must not be negative");
  end

  state_t           state_q, state_d;
  logic             seq_done_q, seq_done_d;
  logic             seq_dir_q, seq_dir_d;
  logic             err_pulse_q, err_pulse_d;
  logic             err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0] done_count_q, done_count_d;
  logic             dir_left_q, dir_left_d;
  logic             dir_right_q, dir_right_d;
  logic             hold_ok;

  // Pattern that must be on the bus while sitting in a sweep state.
  function automatic logic [5:0] own_pattern(input state_t s);
    case (s)
      L1:      own_pattern = 6'b001_000;
      L2:      own_pattern = 6'b011_000;
      L3:      own_pattern = 6'b111_000;
      R1:      own_pattern = 6'b000_001;
      R2:      own_pattern = 6'b000_011;
      R3:      own_pattern = 6'b000_111;
      default: own_pattern = 6'b000_000;
    endcase
  endfunction

  // Pattern that legally advances a sweep state; the last step returns to 000000.
  function automatic logic [5:0] advance_pattern(input state_t s);
    case (s)
      L1:      advance_pattern = 6'b011_000;
      L2:      advance_pattern = 6'b111_000;
      R1:      advance_pattern = 6'b000_011;
      R2:      advance_pattern = 6'b000_111;
      default: advance_pattern = 6'b000_000;
    endcase
  endfunction

  // Saturating increment of the completed-sweep counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

`ifdef TAIL_DECODER_HOLD_EN
  localparam int HOLD_W = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

  logic [HOLD_W-1:0] hold_q, hold_d;

  // A repeat of the current step's own pattern is tolerated while budget remains.
  always_comb begin
    hold_ok = (state_q != IDLE) && (state_q != ERR) &&
              (bus.light == own_pattern(state_q)) &&
              (hold_q < HOLD_W'(HOLD_MAX));
    hold_d  = '0;
    if (hold_ok && (state_d == state_q)) begin
      hold_d = hold_q + 1'b1;
    end
  end

  // Hold counter register; cleared by reset and on every state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  assign hold_ok = 1'b0;
`endif

  // Next-state and next-output decode from the sampled light pattern.
  always_comb begin
    state_d     = state_q;
    seq_done_d  = 1'b0;
    seq_dir_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.light == 6'b000_000) begin
          state_d = IDLE;
        end else if (bus.light == 6'b001_000) begin
          state_d = L1;
        end else if (bus.light == 6'b000_001) begin
          state_d = R1;
        end else begin
          state_d = ERR;
        end
      end
      L1, L2, R1, R2: begin
        if (bus.light == advance_pattern(state_q)) begin
          state_d = state_t'(state_q + 3'd1);
        end else if (!hold_ok) begin
          state_d = ERR;
        end
      end
      L3, R3: begin
        if (bus.light == 6'b000_000) begin
          state_d    = IDLE;
          seq_done_d = 1'b1;
          seq_dir_d  = (state_q == R3);
        end else if (!hold_ok) begin
          state_d = ERR;
        end
      end
      default: begin
        if (bus.light == 6'b000_000) begin
          state_d = IDLE;
        end
      end
    endcase

    err_pulse_d  = (state_d == ERR) && (state_q != ERR);
    err_sticky_d = err_pulse_d | (err_sticky_q & ~bus.err_clr);
    done_count_d = seq_done_d ? sat_inc(done_count_q) : done_count_q;
    dir_left_d   = (state_d == L1) || (state_d == L2) || (state_d == L3);
    dir_right_d  = (state_d == R1) || (state_d == R2) || (state_d == R3);
  end

  // State and output registers; reset overrides any sweep in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      seq_done_q   <= 1'b0;
      seq_dir_q    <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      done_count_q <= '0;
      dir_left_q   <= 1'b0;
      dir_right_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      seq_done_q   <= seq_done_d;
      seq_dir_q    <= seq_dir_d;
      err_pulse_q  <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
      done_count_q <= done_count_d;
      dir_left_q   <= dir_left_d;
      dir_right_q  <= dir_right_d;
    end
  end

  assign bus.dir_left   = dir_left_q;
  assign bus.dir_right  = dir_right_q;
  assign bus.seq_done   = seq_done_q;
  assign bus.seq_dir    = seq_dir_q;
  assign bus.err_pulse  = err_pulse_q;
  assign bus.err_sticky = err_sticky_q;
  assign bus.done_count = done_count_q;

endmodule

// File: doc/tail_light_decoder.md
Name: tail_light_decoder

Overview:
- Receive-side monitor for the 6-bit tail-light bus driven by the tail-light sequencer.
- Samples light every clock and tracks the legal sweep for each side:
  - Left group light[5:3]: 001, 011, 111, then 000.
  - Right group light[2:0]: same sequence.
- Reports the active direction, signals each completed sweep, counts completed sweeps, and flags any illegal pattern or ordering.
- Sits on the observation side (board checker or self-test) and drives status LEDs.

Parameters:
- CNT_W, 8: width of the completed-sweep counter.
- HOLD_MAX, 3: extra cycles a pattern may repeat before it counts as an error. Used only with TAIL_DECODER_HOLD_EN.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- light  input  6  observed tail-light bus. [5:3] = left group, [2:0] = right group.
- err_clr  input  1  single-cycle clear of err_sticky.
- dir_left  output  1  high while a left sweep is in progress.
- dir_right  output  1  high while a right sweep is in progress.
- seq_done  output  1  one-cycle pulse when a full sweep completes.
- seq_dir  output  1  direction of the completed sweep (0 = left, 1 = right). Valid only while seq_done = 1.
- err_pulse  output  1  one-cycle pulse on detection of an illegal pattern or transition.
- err_sticky  output  1  latched error flag.
- done_count  output  CNT_W  saturating count of completed sweeps.

Behaviour:
- Reset (synchronous, active-high):
  - State = IDLE; hold counter = 0.
  - All outputs = 0, including done_count = 0.
  - Reset has priority over every other event, including a sweep in progress.
- Timing:
  - All outputs are registered.
  - The light value sampled at edge k determines the state and outputs visible after edge k (1-cycle latency).
- States: IDLE, L1, L2, L3, R1, R2, R3, ERR.
- Let P denote the sampled light value.
- IDLE:
  - P = 000000: stay.
  - P = 001000: go to L1.
  - P = 000001: go to R1.
  - Any other P: go to ERR.
- L1 -> L2 on 011000; L2 -> L3 on 111000.
- R1 -> R2 on 000011; R2 -> R3 on 000111.
- L3 or R3:
  - P = 000000: go to IDLE and assert seq_done for one cycle; seq_dir = 0 from L3, 1 from R3.
  - done_count increments by 1 and saturates at all-ones.
- Any other P in L1..R3 goes to ERR. This covers:
  - the pattern held unchanged (unless hold tolerance applies);
  - both groups nonzero;
  - a skipped step;
  - the wrong group.
- ERR:
  - err_pulse = 1 on the cycle of entry only.
  - Stay in ERR until P = 000000, then go to IDLE. No seq_done is generated.
  - While in ERR, do not re-pulse err_pulse.
- dir_left = 1 in L1..L3; dir_right = 1 in R1..R3; both 0 in IDLE and ERR.
- err_sticky:
  - Set on any err_pulse.
  - Cleared by err_clr.
  - If err_clr and a new error occur in the same cycle, set wins.
- Back-to-back sweeps:
  - The sequencer always inserts one 000000 cycle between sweeps. That cycle both completes the sweep and returns to IDLE.
  - A following 001000 or 000001 then starts a new sweep with no gap error.
- Direction change between sweeps (L then R) is legal.

Optional Feature:
- Macro: TAIL_DECODER_HOLD_EN.
- Defined:
  - In L1..R3, P equal to the current state's own pattern is tolerated for up to HOLD_MAX consecutive extra cycles.
  - The hold counter resets on every state change.
  - Hold cycle HOLD_MAX+1 goes to ERR.
  - IDLE holding 000000 is always legal.
  - Purpose: supports sequencers driven by a slower enable.
- Undefined:
  - Any repeat of a non-zero pattern is an immediate error.
  - No hold counter is synthesized; HOLD_MAX is ignored.

Test Plan:
- Reset, then light 000000,001000,011000,111000,000000 -> dir_left high for 3 cycles; seq_done=1 with seq_dir=0 one cycle after the final 000000 is sampled; done_count=1; err_sticky=0.
- Right sweep 000001,000011,000111,000000 immediately followed by a left sweep -> two seq_done pulses (seq_dir 1 then 0); done_count=2; no error.
- Illegal 001001 from IDLE -> err_pulse for one cycle, err_sticky=1, dir_* = 0. Then 000000 -> IDLE. Then err_clr -> err_sticky=0.
- Skip 001000,111000 -> ERR one cycle after 111000 is sampled; no seq_done. Reset asserted mid-sweep (state L2) -> all outputs 0 on the next cycle.
- CNT_W=2, five full left sweeps -> done_count = 1,2,3,3,3 (saturates).
- TAIL_DECODER_HOLD_EN, HOLD_MAX=3: 001000 ×4 then 011000,111000,000000 -> no error, one seq_done. 001000 ×5 -> err_pulse. Macro off: 001000 ×2 -> err_pulse.
